// File: rtl/sccb_request_arbiter_pkg.sv
// Package: sccb_arb_pkg
// Purpose: shared constants for the SCCB request arbiter -- FSM state
//          encoding, timer width and SCCB register address/data width.
// Contents:
//   TIMER_W        width of the WAIT_BUSY / WAIT_DONE timer and gap counter
//   SCCB_W         width of an SCCB register address or data byte
//   ST_*           arbiter FSM state codes
package sccb_arb_pkg;

    localparam int TIMER_W = 32;
    localparam int SCCB_W  = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

endpackage

// File: rtl/sccb_request_arbiter_rr_select.sv
// Module: sccb_rr_select
// Purpose: combinational winner pick for the SCCB arbiter. Requester 0 can be
//          given absolute priority; otherwise the search starts just after the
//          last granted requester and wraps, giving round-robin fairness.
// Ports:
//   req_i         requester level vector
//   last_grant_i  index of the most recent grant
//   prio_req0_i   1: req_i[0] wins whenever it is set
//   valid_o       some requester is asking
//   idx_o         index of the winner (0 when valid_o is low)
module sccb_rr_select #(
    parameter int NUM_REQ = 2,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_grant_i,
    input  logic               prio_req0_i,
    output logic               valid_o,
    output logic [IDW-1:0]     idx_o
);

    logic found;
    int   j;

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        if (prio_req0_i && req_i[0]) begin
            found = 1'b1;
        end else begin
            // Scan last+1, last+2, ... wrapping; the first set bit wins.
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = int'(last_grant_i) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                if (!found && req_i[j[IDW-1:0]]) begin
                    idx_o = j[IDW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sccb_request_arbiter.sv
// Module: sccb_request_arbiter
// Purpose: shares one SCCB register-write interface among NUM_REQ requesters.
//          Grants one write at a time, issues a one-cycle start with the
//          latched address/data, follows the interface ready handshake to
//          completion (ready falls = accepted, ready rises = finished), reports
//          done or timeout per requester and enforces an idle gap afterwards.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req / req_addr / req_data per-requester level request and 8-bit payloads
//   req_ack / req_done / req_err  per-requester one-cycle status pulses
//   SCCB_interface_ready      interface idle/ready
//   SCCB_interface_addr/data  latched payload of the write in flight
//   SCCB_interface_start      one-cycle start pulse (same edge as req_ack)
//   busy                      high whenever the arbiter is not idle
//   grant_id                  index of the current/last granted requester
module sccb_request_arbiter
    import sccb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int CLK_FREQ       = 25000000,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int PRIORITY_REQ0  = 1,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    input  logic                   SCCB_interface_ready,
    output logic [SCCB_W-1:0]      SCCB_interface_addr,
    output logic [SCCB_W-1:0]      SCCB_interface_data,
    output logic                   SCCB_interface_start,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id
);

    // Counts are in clk cycles; CLK_FREQ only documents the intended rate.
    // A non-positive timeout would underflow the compare value, so clamp to 1.
    localparam int TIMEOUT_EFF = (CLK_FREQ > 0 && TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_EFF - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD     = TIMER_W'(GAP_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_MAX    = '1;

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] gap_q, gap_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [SCCB_W-1:0]  addr_q, addr_d;
    logic [SCCB_W-1:0]  data_q, data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;

    logic               sel_valid;
    logic [IDW-1:0]     sel_idx;
    logic               timed_out;
    logic [TIMER_W-1:0] timer_inc;

    sccb_rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_sel (
        .req_i        (req),
        .last_grant_i (last_q),
        .prio_req0_i  (PRIORITY_REQ0 != 0),
        .valid_o      (sel_valid),
        .idx_o        (sel_idx)
    );

    assign timed_out = (timer_q == TIMEOUT_LAST);
    // Saturate instead of wrapping so a stuck timer can never alias back to 0.
    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gap_d   = gap_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        start_d = 1'b0;
        ack_d   = '0;
        done_d  = '0;
        err_d   = '0;

        case (state_q)
            ST_IDLE: begin
                // Ready low here also covers an interface still finishing a
                // write that was in flight when the arbiter was reset.
                if (SCCB_interface_ready && sel_valid) begin
                    addr_d           = req_addr[int'(sel_idx)*SCCB_W +: SCCB_W];
                    data_d           = req_data[int'(sel_idx)*SCCB_W +: SCCB_W];
                    start_d          = 1'b1;
                    ack_d[sel_idx]   = 1'b1;
                    grant_d          = sel_idx;
                    last_d           = sel_idx;
                    timer_d          = '0;
                    state_d          = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                // Only the falling edge of ready means the interface took the
                // write; ready staying (or glitching) high is not progress.
                if (!SCCB_interface_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT_DONE;
                end else if (timed_out) begin
                    err_d[grant_q] = 1'b1;
                    gap_d          = GAP_LOAD;
                    state_d        = ST_GAP;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (SCCB_interface_ready) begin
                    done_d[grant_q] = 1'b1;
                    gap_d           = GAP_LOAD;
                    state_d         = ST_GAP;
                end else if (timed_out) begin
                    err_d[grant_q] = 1'b1;
                    gap_d          = GAP_LOAD;
                    state_d        = ST_GAP;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                // GAP: loaded with GAP_CYCLES, so it spans GAP_CYCLES+1 cycles.
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - TIMER_W'(1);
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            gap_q   <= '0;
            // Makes requester 0 first in round-robin order after reset.
            last_q  <= IDW'(NUM_REQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ack              = ack_q;
    assign req_done             = done_q;
    assign req_err              = err_q;
    assign SCCB_interface_addr  = addr_q;
    assign SCCB_interface_data  = data_q;
    assign SCCB_interface_start = start_q;
    assign busy                 = busy_q;
    assign grant_id             = grant_q;

endmodule

// File: tb/tb_sccb_request_arbiter.sv
// Testbench for sccb_request_arbiter. Two instances share all inputs: one in
// pure round-robin mode, one with requester 0 priority. A transaction-level
// model predicts every output of both instances each cycle; directed scenarios
// add hand-computed literal expectations.
module tb_sccb_request_arbiter;

    localparam int N   = 3;
    localparam int GAP = 4;
    localparam int TMO = 50;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ready = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_data = '0;

    logic [N-1:0] ack_o  [2];
    logic [N-1:0] done_o [2];
    logic [N-1:0] err_o  [2];
    logic [7:0]   addr_o [2];
    logic [7:0]   data_o [2];
    logic         start_o[2];
    logic         busy_o [2];
    logic [1:0]   gid_o  [2];

    always #5 clk = ~clk;

    sccb_request_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .PRIORITY_REQ0(0)) u_rr (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_ack(ack_o[0]), .req_done(done_o[0]), .req_err(err_o[0]),
        .SCCB_interface_ready(ready), .SCCB_interface_addr(addr_o[0]), .SCCB_interface_data(data_o[0]),
        .SCCB_interface_start(start_o[0]), .busy(busy_o[0]), .grant_id(gid_o[0]));

    sccb_request_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .PRIORITY_REQ0(1)) u_pr (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .req_ack(ack_o[1]), .req_done(done_o[1]), .req_err(err_o[1]),
        .SCCB_interface_ready(ready), .SCCB_interface_addr(addr_o[1]), .SCCB_interface_data(data_o[1]),
        .SCCB_interface_start(start_o[1]), .busy(busy_o[1]), .grant_id(gid_o[1]));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ---------------- transaction-level model ----------------
    // A write is: free -> issued (waiting for the interface to take it)
    // -> accepted (waiting for it to finish) -> cooling (idle gap) -> free.
    typedef enum int {M_FREE, M_ISSUED, M_ACCEPTED, M_COOLING} mphase_t;
    mphase_t    ph[2];
    int         t0[2];
    int         mlast[2];
    logic [N-1:0] e_ack[2], e_done[2], e_err[2];
    logic       e_start[2], e_busy[2];
    logic [1:0] e_gid[2];
    logic [7:0] e_addr[2], e_data[2];

    function automatic int pick(input int d);
        if (d == 1 && req[0]) return 0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (mlast[d] + k) % N;
            if (req[j]) return j;
        end
        return 0;
    endfunction

    always @(posedge clk) begin : model_p
        int w;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            e_start[d] = 1'b0;
            e_ack[d]   = '0;
            e_done[d]  = '0;
            e_err[d]   = '0;
            if (rst) begin
                ph[d]     = M_FREE;
                mlast[d]  = N - 1;
                e_gid[d]  = '0;
                e_addr[d] = '0;
                e_data[d] = '0;
            end else begin
                case (ph[d])
                    M_FREE: if (ready && req != '0) begin
                        w            = pick(d);
                        e_start[d]   = 1'b1;
                        e_ack[d][w]  = 1'b1;
                        e_gid[d]     = 2'(w);
                        e_addr[d]    = req_addr[8*w +: 8];
                        e_data[d]    = req_data[8*w +: 8];
                        mlast[d]     = w;
                        ph[d]        = M_ISSUED;
                        t0[d]        = cyc;
                    end
                    M_ISSUED: if (!ready) begin
                        ph[d] = M_ACCEPTED;
                        t0[d] = cyc;
                    end else if (cyc - t0[d] == TMO) begin
                        e_err[d][e_gid[d]] = 1'b1;
                        ph[d] = M_COOLING;
                        t0[d] = cyc;
                    end
                    M_ACCEPTED: if (ready) begin
                        e_done[d][e_gid[d]] = 1'b1;
                        ph[d] = M_COOLING;
                        t0[d] = cyc;
                    end else if (cyc - t0[d] == TMO) begin
                        e_err[d][e_gid[d]] = 1'b1;
                        ph[d] = M_COOLING;
                        t0[d] = cyc;
                    end
                    default: if (cyc - t0[d] == GAP + 1) ph[d] = M_FREE;
                endcase
            end
            e_busy[d] = (ph[d] != M_FREE);
        end
    end

    // ---------------- compare + event log ----------------
    int n_ack[2][N]  = '{default: 0};
    int n_done[2][N] = '{default: 0};
    int n_err[2][N]  = '{default: 0};
    int n_start[2]   = '{default: 0};
    int st_cyc[2]    = '{default: 0};
    int er_cyc[2]    = '{default: 0};
    int glog0[$], glog1[$], scyc0[$];

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk(d, "start", 32'(start_o[d]), 32'(e_start[d]));
            chk(d, "ack",   32'(ack_o[d]),   32'(e_ack[d]));
            chk(d, "done",  32'(done_o[d]),  32'(e_done[d]));
            chk(d, "err",   32'(err_o[d]),   32'(e_err[d]));
            chk(d, "busy",  32'(busy_o[d]),  32'(e_busy[d]));
            chk(d, "gid",   32'(gid_o[d]),   32'(e_gid[d]));
            chk(d, "addr",  32'(addr_o[d]),  32'(e_addr[d]));
            chk(d, "data",  32'(data_o[d]),  32'(e_data[d]));
            if (start_o[d] === 1'b1) begin
                n_start[d]++;
                st_cyc[d] = cyc;
                if (d == 0) begin glog0.push_back(int'(gid_o[0])); scyc0.push_back(cyc); end
                else        glog1.push_back(int'(gid_o[1]));
            end
            if (err_o[d] !== '0) er_cyc[d] = cyc;
            for (int r = 0; r < N; r++) begin
                if (ack_o[d][r]  === 1'b1) n_ack[d][r]++;
                if (done_o[d][r] === 1'b1) n_done[d][r]++;
                if (err_o[d][r]  === 1'b1) n_err[d][r]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int k = 0;
        while (e_start[0] !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        n_tests++;
        if (e_start[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_start: no grant after %0d cycles, expected one", k);
        end
    endtask

    // Interface behaviour: take the write lo_delay cycles after start,
    // stay busy for lo_len cycles, then report completion.
    task automatic serve(input int lo_delay, input int lo_len);
        wait_start();
        repeat (lo_delay) tick();
        ready = 1'b0;
        repeat (lo_len) tick();
        ready = 1'b1;
    endtask

    int exp_rr[4] = '{0, 1, 2, 0};
    int b0, b1, s0, a1, d2, e0;

    initial begin
        // Reset state
        repeat (3) tick();
        lit("rst_busy", int'(busy_o[0]), 0);
        lit("rst_gid",  int'(gid_o[1]), 0);
        lit("rst_ack",  int'(ack_o[0]), 0);
        rst = 1'b0;

        // 1: single write from requester 1
        req_addr[15:8] = 8'h12;
        req_data[15:8] = 8'h80;
        req = 3'b010;
        tick();
        lit("t1_start", int'(start_o[0]), 1);
        lit("t1_ack",   int'(ack_o[0]), 2);
        lit("t1_addr",  int'(addr_o[0]), 'h12);
        lit("t1_data",  int'(data_o[0]), 'h80);
        lit("t1_gid",   int'(gid_o[1]), 1);
        req = '0;
        tick(); tick();
        ready = 1'b0;
        repeat (30) tick();
        ready = 1'b1;
        repeat (GAP + 4) tick();
        lit("t1_done_cnt",  n_done[0][1], 1);
        lit("t1_err_cnt",   n_err[0][1], 0);
        lit("t1_start_cnt", n_start[0], 1);

        // 2: contention from a fresh reset, all requests held
        rst = 1'b1; tick(); rst = 1'b0;
        req_addr = {8'h32, 8'h22, 8'h12};
        req_data = {8'hC2, 8'hB1, 8'hA0};
        b0 = glog0.size();
        b1 = glog1.size();
        req = 3'b111;
        for (int i = 0; i < 4; i++) serve(2, 5);
        req = '0;
        repeat (GAP + 4) tick();
        for (int i = 0; i < 4; i++) begin
            lit($sformatf("t2_rr_order%0d", i), (glog0.size() > b0 + i) ? glog0[b0 + i] : -1, exp_rr[i]);
            lit($sformatf("t2_pr_order%0d", i), (glog1.size() > b1 + i) ? glog1[b1 + i] : -1, 0);
        end
        for (int i = 1; i < 4; i++)
            lit($sformatf("t2_spacing%0d", i),
                (scyc0.size() > b0 + i && scyc0[b0 + i] - scyc0[b0 + i - 1] >= GAP + 2) ? 1 : 0, 1);

        // 3: requester 0 priority
        b1 = glog1.size();
        req = 3'b011;
        serve(2, 5);
        serve(2, 5);
        req = 3'b010;
        serve(2, 5);
        req = '0;
        repeat (GAP + 4) tick();
        lit("t3_pr0", (glog1.size() > b1)     ? glog1[b1]     : -1, 0);
        lit("t3_pr1", (glog1.size() > b1 + 1) ? glog1[b1 + 1] : -1, 0);
        lit("t3_pr2", (glog1.size() > b1 + 2) ? glog1[b1 + 2] : -1, 1);

        // 4: interface never accepts -> timeout in WAIT_BUSY
        d2 = n_done[0][2];
        e0 = n_err[0][2];
        req = 3'b100;
        wait_start();
        req = '0;
        repeat (TMO + GAP + 4) tick();
        lit("t4_err_cnt",  n_err[0][2] - e0, 1);
        lit("t4_done_cnt", n_done[0][2] - d2, 0);
        lit("t4_err_lat",  er_cyc[0] - st_cyc[0], TMO);
        lit("t4_idle",     int'(busy_o[0]), 0);

        // 4b: interface accepts but never finishes -> timeout in WAIT_DONE
        req = 3'b001;
        wait_start();
        req = '0;
        tick(); tick();
        ready = 1'b0;
        repeat (TMO + 5) tick();
        ready = 1'b1;
        repeat (GAP + 4) tick();
        lit("t4b_err_lat", er_cyc[0] - st_cyc[0], TMO + 3);

        // 5: reset while the interface is busy
        req = 3'b001;
        wait_start();
        tick(); tick();
        ready = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        lit("t5_busy",  int'(busy_o[0]), 0);
        lit("t5_start", int'(start_o[0]), 0);
        s0 = n_start[0];
        repeat (10) tick();
        lit("t5_no_grant", n_start[0] - s0, 0);
        ready = 1'b1;
        tick();
        lit("t5_regrant", int'(start_o[0]), 1);
        lit("t5_ack",     int'(ack_o[0]), 1);
        req = '0;
        tick();
        ready = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        repeat (GAP + 4) tick();

        // 6: request withdrawn before it could be granted
        ready = 1'b0;
        tick();
        s0 = n_start[0];
        a1 = n_ack[0][1];
        req = 3'b010;
        tick();
        req = '0;
        repeat (5) tick();
        ready = 1'b1;
        repeat (10) tick();
        lit("t6_no_ack",   n_ack[0][1] - a1, 0);
        lit("t6_no_start", n_start[0] - s0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
